// File: rtl/ftdi_io_deser_pkg.sv
// rtl/ftdi_io_deser_pkg.sv - shared FSM encoding and parameter limits for the serial deserializer
package ftdi_io_deser_pkg;

  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_e;

  localparam int unsigned CChCntMin   = 1;
  localparam int unsigned CChCntMax   = 8;
  localparam int unsigned CWordLenMin = 2;
  localparam int unsigned CWordLenMax = 32;

  // Bit-counter width; counts 0..word_len-1.
  function automatic int unsigned cnt_width(input int unsigned word_len);
    return (word_len <= 2) ? 1 : $clog2(word_len);
  endfunction

endpackage

// File: rtl/ftdi_io_deser_ch.sv
// rtl/ftdi_io_deser_ch.sv - one channel's shift register; word_o is the value after the current strobe
module ftdi_io_deser_ch
  import ftdi_io_deser_pkg::*;
#(
  parameter int unsigned CWordLen  = 8,
  parameter bit          CMsbFirst = 1'b1
) (
  input  logic                AClkH,
  input  logic                AResetHN,
  input  logic                shift_en_i,
  input  logic                start_i,
  input  logic                bit_i,
  output logic [CWordLen-1:0] word_o
);

  logic [CWordLen-1:0] sr_q;
  logic [CWordLen-1:0] sr_d;
  logic [CWordLen-1:0] base;

  // A frame bit starts from an empty register so stale partial bits never leak.
  always_comb begin
    base = start_i ? '0 : sr_q;
    sr_d = sr_q;
    if (shift_en_i) begin
      if (CMsbFirst) begin
        sr_d = {base[CWordLen-2:0], bit_i};
      end else begin
        sr_d = {bit_i, base[CWordLen-1:1]};
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign word_o = sr_d;

endmodule

// File: rtl/ftdi_io_deser.sv
// rtl/ftdi_io_deser.sv - multi-channel framed serial-to-parallel deserializer with holding register
module ftdi_io_deser
  import ftdi_io_deser_pkg::*;
#(
  parameter int unsigned CChCnt    = 1,
  parameter int unsigned CWordLen  = 8,
  parameter bit          CMsbFirst = 1'b1
) (
  input  logic                       AClkH,
  input  logic                       AResetHN,
  input  logic                       AClkHEn,
  input  logic                       ABitStb,
  input  logic                       AFrameI,
  input  logic [CChCnt-1:0]          ADataI,
  output logic [CChCnt*CWordLen-1:0] ADataO,
  output logic                       AValidO,
  input  logic                       AReadyI,
  output logic                       AOvrO,
  output logic                       AFrmErrO,
  input  logic                       AErrClr
);

  localparam int unsigned CntW = cnt_width(CWordLen);
  localparam logic [CntW-1:0] CLastCnt = CntW'(CWordLen - 1);

  deser_state_e                state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [CChCnt*CWordLen-1:0]  data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ovr_q, ovr_d;
  logic                        frm_q, frm_d;
  logic [CChCnt*CWordLen-1:0]  word_next;
  logic                        stb;
  logic                        shift_en;
  logic                        start;
  logic                        complete;
  logic                        ovr_set;
  logic                        frm_set;

  assign stb = AClkHEn & ABitStb;

  for (genvar g = 0; g < CChCnt; g++) begin : g_ch
    ftdi_io_deser_ch #(
      .CWordLen  (CWordLen),
      .CMsbFirst (CMsbFirst)
    ) u_ch (
      .AClkH      (AClkH),
      .AResetHN   (AResetHN),
      .shift_en_i (shift_en),
      .start_i    (start),
      .bit_i      (ADataI[g]),
      .word_o     (word_next[g*CWordLen +: CWordLen])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    start    = 1'b0;
    complete = 1'b0;
    frm_set  = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (stb && AFrameI) begin
          shift_en = 1'b1;
          start    = 1'b1;
          cnt_d    = CntW'(1);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stb) begin
          shift_en = 1'b1;
          if (AFrameI) begin
            start   = 1'b1;
            frm_set = (cnt_q != '0);
            cnt_d   = CntW'(1);
          end else if (cnt_q == CLastCnt) begin
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Holding register: a completing word loads only if the slot is free or being drained now.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (complete) begin
      if (!valid_q || AReadyI) begin
        data_d  = word_next;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && AReadyI) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_set | (ovr_q & ~AErrClr);
    frm_d = frm_set | (frm_q & ~AErrClr);
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q <= ST_HUNT;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else if (AClkHEn) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      frm_q   <= frm_d;
    end
  end

  assign ADataO   = data_q;
  assign AValidO  = valid_q;
  assign AOvrO    = ovr_q;
  assign AFrmErrO = frm_q;

endmodule

// File: tb/tb_ftdi_io_deser.sv
// tb/tb_ftdi_io_deser.sv - directed and random checks of MSB-first and LSB-first deserializers
module tb_ftdi_io_deser;

  logic        AClkH    = 1'b0;
  logic        AResetHN = 1'b0;
  logic        AClkHEn  = 1'b0;
  logic        ABitStb  = 1'b0;
  logic        AFrameI  = 1'b0;
  logic [1:0]  ADataI   = 2'b00;
  logic        AReadyI  = 1'b0;
  logic        AErrClr  = 1'b0;
  logic [15:0] m_dout, l_dout;
  logic        m_valid, l_valid, m_ovr, l_ovr, m_frm, l_frm;

  int total = 0;
  int bad   = 0;

  // Reference state: collected bits per channel in arrival order plus the consumer-side view.
  bit        r_aligned;
  int        r_n;
  bit [7:0]  r_seq0, r_seq1;
  bit        r_valid, r_ovr, r_frm;
  bit [15:0] r_dm, r_dl;

  always #5 AClkH = ~AClkH;

  ftdi_io_deser #(.CChCnt(2), .CWordLen(8), .CMsbFirst(1'b1)) u_dut_msb (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .ABitStb(ABitStb),
    .AFrameI(AFrameI), .ADataI(ADataI), .ADataO(m_dout), .AValidO(m_valid),
    .AReadyI(AReadyI), .AOvrO(m_ovr), .AFrmErrO(m_frm), .AErrClr(AErrClr)
  );

  ftdi_io_deser #(.CChCnt(2), .CWordLen(8), .CMsbFirst(1'b0)) u_dut_lsb (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .ABitStb(ABitStb),
    .AFrameI(AFrameI), .ADataI(ADataI), .ADataO(l_dout), .AValidO(l_valid),
    .AReadyI(AReadyI), .AOvrO(l_ovr), .AFrmErrO(l_frm), .AErrClr(AErrClr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] first_in_msb(input bit [7:0] seq);
    bit [7:0] w = 8'd0;
    for (int i = 0; i < 8; i++) if (seq[i]) w = w + 8'(1 << (7 - i));
    return w;
  endfunction

  task automatic model_reset();
    r_aligned = 1'b0; r_n = 0; r_seq0 = '0; r_seq1 = '0;
    r_valid = 1'b0; r_ovr = 1'b0; r_frm = 1'b0; r_dm = '0; r_dl = '0;
  endtask

  task automatic model_edge(input bit en, input bit stb, input bit frm,
                            input bit [1:0] d, input bit rdy, input bit clr);
    bit done = 1'b0, ovr_set = 1'b0, frm_set = 1'b0;
    if (!en) return;
    if (stb) begin
      if (frm) begin
        if (r_aligned && r_n != 0) frm_set = 1'b1;
        r_aligned = 1'b1;
        r_seq0 = '0; r_seq1 = '0;
        r_seq0[0] = d[0]; r_seq1[0] = d[1];
        r_n = 1;
      end else if (r_aligned) begin
        r_seq0[r_n] = d[0]; r_seq1[r_n] = d[1];
        r_n++;
        if (r_n == 8) begin
          done = 1'b1;
          r_n  = 0;
        end
      end
    end
    if (done) begin
      if (!r_valid || rdy) begin
        r_valid = 1'b1;
        r_dm = {first_in_msb(r_seq1), first_in_msb(r_seq0)};
        r_dl = {r_seq1, r_seq0};
      end else begin
        ovr_set = 1'b1;
      end
    end else if (r_valid && rdy) begin
      r_valid = 1'b0;
    end
    r_ovr = ovr_set | (r_ovr & !clr);
    r_frm = frm_set | (r_frm & !clr);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_m"}, 32'(m_valid), 32'(r_valid));
    chk({tag, ".valid_l"}, 32'(l_valid), 32'(r_valid));
    chk({tag, ".data_m"},  32'(m_dout),  32'(r_dm));
    chk({tag, ".data_l"},  32'(l_dout),  32'(r_dl));
    chk({tag, ".ovr_m"},   32'(m_ovr),   32'(r_ovr));
    chk({tag, ".ovr_l"},   32'(l_ovr),   32'(r_ovr));
    chk({tag, ".frm_m"},   32'(m_frm),   32'(r_frm));
    chk({tag, ".frm_l"},   32'(l_frm),   32'(r_frm));
  endtask

  task automatic step(input bit en, input bit stb, input bit frm,
                      input bit [1:0] d, input bit rdy, input bit clr);
    @(negedge AClkH);
    AClkHEn = en; ABitStb = stb; AFrameI = frm; ADataI = d; AReadyI = rdy; AErrClr = clr;
    model_edge(en, stb, frm, d, rdy, clr);
    @(posedge AClkH);
    #1;
    check_all("step");
  endtask

  task automatic send_word(input bit [7:0] s0, input bit [7:0] s1, input bit framed, input bit rdy);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, framed && (i == 0), {s1[i], s0[i]}, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge AClkH);
    ABitStb = 1'b0;
    #2 AResetHN = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge AClkH);
    AResetHN = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge AClkH);
    #1;
    check_all("reset");
    @(negedge AClkH);
    AResetHN = 1'b1;
    AClkHEn  = 1'b1;

    // First-bit framing, both bit orders, single-cycle valid pulse.
    send_word(8'hA5, 8'hFF, 1'b1, 1'b1);
    chk("w1_data_m", 32'(m_dout), 32'h0000FFA5);
    chk("w1_valid",  32'(m_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("w1_pulse",  32'(m_valid), 32'd0);
    send_word(8'h03, 8'hFF, 1'b1, 1'b1);
    chk("w2_data_l", 32'(l_dout), 32'h0000FF03);
    chk("w2_data_m", 32'(m_dout), 32'h0000FFC0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

    // Overrun: hold the first word, drop the second, then clear the flag.
    send_word(8'h35, 8'h81, 1'b1, 1'b0);
    send_word(8'hF0, 8'h0F, 1'b0, 1'b0);
    chk("ovr_hold", 32'(m_dout), 32'h000081AC);
    chk("ovr_set",  32'(m_ovr), 32'd1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    chk("ovr_clr",  32'(m_ovr), 32'd0);
    chk("ovr_vld",  32'(m_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

    // Re-frame on the 4th strobe of a word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i == 0, 2'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("frm_set", 32'(m_frm), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 2'($urandom), 1'b1, 1'b0);
    chk("frm_nopart", 32'(m_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    chk("frm_word", 32'(m_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    chk("frm_clr", 32'(m_frm), 32'd0);

    // Completion while the held word is being accepted.
    send_word(8'hFF, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, {1'(i == 1), 1'(i == 0)}, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("b2b_valid", 32'(m_valid), 32'd1);
    chk("b2b_data",  32'(m_dout), 32'h00004080);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

    // Reset mid-word, then unframed strobes must not produce a word.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 2'b10, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("rst_novalid", 32'(m_valid), 32'd0);
    send_word(8'h5A, 8'h0F, 1'b1, 1'b1);
    chk("rst_word", 32'(l_dout), 32'h00000F5A);

    // Random traffic including gated enables, clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
           2'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ftdi_io_deser.md
FTDI_IO_DESER -- requirements
Module: ftdi_io_deser

Interface
REQ-001 SHALL have parameter CChCnt, default 1, number of parallel serial channels (1..8).
REQ-002 SHALL have parameter CWordLen, default 8, bits per word (2..32).
REQ-003 SHALL have parameter CMsbFirst, default 1; 1 = first received bit lands in word MSB, 0 = in LSB.
REQ-004 SHALL have port AClkH  in  1  sole clock, rising edge.
REQ-005 SHALL have port AResetHN  in  1  asynchronous active-low reset.
REQ-006 SHALL have port AClkHEn  in  1  global clock enable; when 0 no register except the reset path changes.
REQ-007 SHALL have port ABitStb  in  1  bit-sample strobe; ADataI and AFrameI are sampled only when ABitStb=1.
REQ-008 SHALL have port AFrameI  in  1  frame marker; 1 marks the sampled bit as bit 0 of a new word.
REQ-009 SHALL have port ADataI  in  CChCnt  one serial bit per channel.
REQ-010 SHALL have port ADataO  out  CChCnt*CWordLen  held words, channel 0 in the least significant CWordLen bits.
REQ-011 SHALL have port AValidO  out  1  ADataO holds an unconsumed word.
REQ-012 SHALL have port AReadyI  in  1  consumer accepts ADataO when AValidO=1 and AReadyI=1.
REQ-013 SHALL have port AOvrO  out  1  sticky overrun flag.
REQ-014 SHALL have port AFrmErrO  out  1  sticky framing-error flag.
REQ-015 SHALL have port AErrClr  in  1  clears AOvrO and AFrmErrO.

Function
REQ-016 SHALL implement a two-state FSM: HUNT (no word alignment) and SHIFT (bit counter active).
REQ-017 In HUNT, SHALL ignore ADataI until a strobe with AFrameI=1; that bit is stored as bit 0 and the FSM enters SHIFT with bit count 1.
REQ-018 In SHIFT, each strobe with AFrameI=0 SHALL shift one bit per channel into its shift register and increment the bit count.
REQ-019 When the strobe carrying bit CWordLen-1 is sampled, the word SHALL be complete, the count SHALL wrap to 0 and the FSM SHALL remain in SHIFT (back-to-back words need no further AFrameI).
REQ-020 A strobe with AFrameI=1 in SHIFT at count 0 SHALL be accepted as normal alignment; at count 1..CWordLen-1 it SHALL discard the partial word, set AFrmErrO, and restart with this bit as bit 0.
REQ-021 With CMsbFirst=1 the shift register SHALL shift toward MSB inserting at LSB; with CMsbFirst=0 it SHALL shift toward LSB inserting at MSB.
REQ-022 A completed word SHALL appear on ADataO with AValidO=1 on the clock edge immediately after the completing strobe is sampled (latency 1 cycle).
REQ-023 AValidO SHALL fall on the edge after a cycle with AValidO=1 and AReadyI=1, unless a new word completes in that same cycle, in which case the new word loads and AValidO stays 1.
REQ-024 If a word completes while AValidO=1 and AReadyI=0, the held word SHALL be kept, the new word dropped, and AOvrO set.
REQ-025 ADataO SHALL remain stable while AValidO=1 and not accepted.
REQ-026 AErrClr=1 SHALL clear both flags on the next enabled edge; a set event in the same cycle SHALL win (flag stays 1).
REQ-027 ABitStb in a cycle with AClkHEn=0 SHALL be ignored.

Reset
REQ-028 AResetHN=0 SHALL asynchronously force FSM to HUNT, bit count 0, shift registers and ADataO to 0, AValidO, AOvrO, AFrmErrO to 0.
REQ-029 Reset asserted mid-word or with AValidO=1 SHALL discard all data; after release the block SHALL wait for AFrameI.

Structure
REQ-030 The FSM state encoding and the channel-count and word-length limits SHALL live in a shared package.
REQ-031 Each channel's shift register SHALL be one instance of sub-module ftdi_io_deser_ch (parameters CWordLen, CMsbFirst), generated CChCnt times; bit counter, FSM, holding register and flags live in the top.

Verification
REQ-032 CChCnt=2, CWordLen=8, CMsbFirst=1: frame on first bit, ch0 bits 1,0,1,0,0,1,0,1, ch1 all 1, AReadyI=1 -> ADataO=16'hFFA5, AValidO pulses 1 cycle, one edge after the 8th strobe.
REQ-033 Same config, CMsbFirst=0, ch0 same bits -> ch0 word 8'hA5 reversed = 8'hA5 bit-mirrored (8'hA5 is palindromic: use 1,1,0,0,0,0,0,0 -> 8'h03).
REQ-034 Two back-to-back words with AReadyI=0 throughout -> first word held on ADataO, AOvrO=1 after second completes; AErrClr then clears AOvrO, AValidO stays 1.
REQ-035 AFrameI=1 on 4th strobe of a word -> AFrmErrO=1, no word emitted for the partial, next word completes 8 strobes after the re-frame strobe.
REQ-036 Word completes in same cycle AValidO=1 and AReadyI=1 -> ADataO updates to new word, AValidO continuous 1.
REQ-037 Reset pulsed after 5 bits, then 8 strobes without AFrameI -> AValidO stays 0; after AFrameI, normal word output.
